// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: turns PS/2 scan-code bytes into a 4-digit code entry and
// arms/disarms on a correct code, with a lockout after repeated failures and an idle timeout.
module keypad_entry_ctrl #(
    parameter logic [15:0] PASSWORD       = 16'h5563,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned LOCK_CYCLES    = 50_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 250_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ps2_data,
    input  logic       ps2_new_data,
    output logic       armed_out,
    output logic       disarmed_out,
    output logic [2:0] digit_count,
    output logic       locked_out,
    output logic       ok_pulse,
    output logic       fail_pulse
);

    localparam int unsigned FAIL_W = 3;
    localparam int unsigned LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam int unsigned TIME_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {ENTRY, BRK, EXT, EXT_BRK, CHECK, LOCK} state_t;

    state_t              state;
    logic [15:0]         code;
    logic [FAIL_W-1:0]   fail_cnt;
    logic [LOCK_W-1:0]   lock_cnt;
    logic [TIME_W-1:0]   idle_cnt;
    logic                digit_valid_c;
    logic [3:0]          digit_val_c;

    // Scan-code to BCD digit decode (main-row number keys)
    always_comb begin
        digit_valid_c = 1'b1;
        digit_val_c   = 4'd0;
        case (ps2_data)
            8'h45: digit_val_c = 4'd0;
            8'h16: digit_val_c = 4'd1;
            8'h1E: digit_val_c = 4'd2;
            8'h26: digit_val_c = 4'd3;
            8'h25: digit_val_c = 4'd4;
            8'h2E: digit_val_c = 4'd5;
            8'h36: digit_val_c = 4'd6;
            8'h3D: digit_val_c = 4'd7;
            8'h3E: digit_val_c = 4'd8;
            8'h46: digit_val_c = 4'd9;
            default: digit_valid_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ENTRY;
            code         <= 16'd0;
            fail_cnt     <= '0;
            lock_cnt     <= '0;
            idle_cnt     <= '0;
            armed_out    <= 1'b0;
            disarmed_out <= 1'b1;
            digit_count  <= 3'd0;
            locked_out   <= 1'b0;
            ok_pulse     <= 1'b0;
            fail_pulse   <= 1'b0;
        end else begin
            ok_pulse   <= 1'b0;
            fail_pulse <= 1'b0;
            case (state)
                CHECK: begin
                    digit_count <= 3'd0;
                    code        <= 16'd0;
                    idle_cnt    <= '0;
                    if (digit_count == 3'd4 && code == PASSWORD) begin
                        armed_out    <= ~armed_out;
                        disarmed_out <= armed_out;
                        fail_cnt     <= '0;
                        ok_pulse     <= 1'b1;
                        state        <= ENTRY;
                    end else begin
                        fail_pulse <= 1'b1;
                        if (fail_cnt == FAIL_W'(MAX_FAILS - 1)) begin
                            fail_cnt   <= '0;
                            locked_out <= 1'b1;
                            lock_cnt   <= '0;
                            state      <= LOCK;
                        end else begin
                            fail_cnt <= fail_cnt + FAIL_W'(1);
                            state    <= ENTRY;
                        end
                    end
                end
                LOCK: begin
                    if (lock_cnt == LOCK_W'(LOCK_CYCLES - 1)) begin
                        lock_cnt   <= '0;
                        locked_out <= 1'b0;
                        state      <= ENTRY;
                    end else begin
                        lock_cnt <= lock_cnt + LOCK_W'(1);
                    end
                end
                default: begin
                    if (ps2_new_data) begin
                        // Any byte restarts the idle timer and takes priority over expiry
                        idle_cnt <= '0;
                        case (state)
                            ENTRY: begin
                                if (ps2_data == 8'hF0) begin
                                    state <= BRK;
                                end else if (ps2_data == 8'hE0) begin
                                    state <= EXT;
                                end else if (ps2_data == 8'h5A) begin
                                    state <= CHECK;
                                end else if (ps2_data == 8'h66) begin
                                    if (digit_count != 3'd0) begin
                                        digit_count <= digit_count - 3'd1;
                                        code        <= {4'd0, code[15:4]};
                                    end
                                end else if (ps2_data == 8'h76) begin
                                    digit_count <= 3'd0;
                                    code        <= 16'd0;
                                end else if (digit_valid_c && digit_count != 3'd4) begin
                                    digit_count <= digit_count + 3'd1;
                                    code        <= {code[11:0], digit_val_c};
                                end
                            end
                            EXT: begin
                                if (ps2_data == 8'hF0) begin
                                    state <= EXT_BRK;
                                end else if (ps2_data == 8'h5A) begin
                                    state <= CHECK;
                                end else begin
                                    state <= ENTRY;
                                end
                            end
                            default: state <= ENTRY;
                        endcase
                    end else if (digit_count != 3'd0) begin
                        if (idle_cnt == TIME_W'(TIMEOUT_CYCLES - 1)) begin
                            idle_cnt    <= '0;
                            digit_count <= 3'd0;
                            code        <= 16'd0;
                            state       <= ENTRY;
                        end else begin
                            idle_cnt <= idle_cnt + TIME_W'(1);
                        end
                    end else begin
                        idle_cnt <= '0;
                    end
                end
            endcase
        end
    end

endmodule
